freq_period_meter: RTL and testbench
====================================

Name: freq_period_meter

Overview:
- Measures an externally generated clock (e.g. a divided clock looped back from a PMOD JA pin) against the on-board 100 MHz clock.
- Reports two results:
  - Edge count over a fixed gate window (frequency).
  - CLK100MHZ cycles between consecutive rising edges (period).
- Serves as the bench-top checker for the divided-clock generators and feeds LED/7-seg display logic.

Parameters:
- GATE_CYCLES, 100_000_000: gate window length in CLK100MHZ cycles. The 1 s default gives freq_count in Hz.
- CNT_W, 32: width of all counters and result outputs.
- SYNC_STAGES, 2: synchronizer flops on sig_in. Minimum 2.
- TIMEOUT_CYCLES, 200_000_000: period-counter limit before no_signal is declared.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- CPU_RESETN  input  1  asynchronous, active-low reset.
- sig_in  input  1  signal under test. Asynchronous to CLK100MHZ.
- freq_count  output  CNT_W  rising edges counted in the last complete gate window.
- freq_valid  output  1  one-cycle pulse when freq_count updates.
- period_cycles  output  CNT_W  CLK100MHZ cycles between the last two rising edges.
- period_valid  output  1  one-cycle pulse when period_cycles updates.
- high_cycles  output  CNT_W  high-time of the last complete pulse (see Optional Feature).
- no_signal  output  1  high while no rising edge has been seen within TIMEOUT_CYCLES.
- overflow  output  1  sticky: some counter saturated. Cleared only by reset.

Behaviour:
- Reset (CPU_RESETN low, asynchronous):
  - All counters, outputs and synchronizer flops go to 0, except no_signal, which goes to 1.
  - Period FSM enters WAIT_FIRST.
- Sync/edge detect:
  - sig_in passes through SYNC_STAGES flops, then one delay flop.
  - rise = sync & ~delayed.
  - A rising edge on sig_in produces rise exactly SYNC_STAGES+1 cycles later.
  - Highest measurable input is 50 MHz; faster inputs alias.
- Gate counter:
  - gate_ctr counts 0..GATE_CYCLES-1 and wraps.
  - edge_ctr increments on each rise.
  - On the cycle gate_ctr==GATE_CYCLES-1:
    - freq_count <= edge_ctr + rise.
    - freq_valid pulses on the next cycle.
    - edge_ctr <= 0.
  - A rise on the final gate cycle belongs to the ending window.
  - First freq_valid arrives GATE_CYCLES cycles after reset release.
- Period FSM:
  - States: WAIT_FIRST, MEASURE, LOST.
  - WAIT_FIRST: per_ctr held at 0. On rise -> MEASURE, per_ctr <= 1.
  - MEASURE, on rise:
    - period_cycles <= per_ctr.
    - period_valid pulses next cycle.
    - per_ctr <= 1.
    - no_signal <= 0.
  - MEASURE, no rise: per_ctr increments.
  - MEASURE, timeout: when per_ctr reaches TIMEOUT_CYCLES -> LOST, no_signal <= 1. period_cycles holds its last value.
  - LOST: on rise -> MEASURE with per_ctr <= 1. The first period after loss is not reported (no valid pulse); the next rise reports normally.
- Saturation:
  - edge_ctr and per_ctr saturate at 2^CNT_W-1 rather than wrapping, and set overflow.
  - A saturated value is still reported.
- Simultaneous events: gate end and period report in the same cycle are independent; both pulses may coincide.
- Reset mid-measurement: discards partial windows. No valid pulse is emitted for an interrupted window.

Optional Feature:
- Macro: FREQ_PERIOD_METER_DUTY_EN.
- Enabled:
  - hi_ctr counts cycles while the synchronized signal is high. It restarts to 1 on rise and saturates like per_ctr.
  - On fall (~sync & delayed) in MEASURE: high_cycles <= hi_ctr.
  - high_cycles is valid on the same period_valid pulse that follows.
- Disabled: high_cycles is tied to 0 and no hi_ctr logic exists. The port list is unchanged.

Decomposition:
- Shared package clk_meas_pkg holds:
  - Period FSM state enum (WAIT_FIRST, MEASURE, LOST).
  - Constant CLK_HZ = 100_000_000.
  - Helper constant function for counter width (clog2).
- One sub-module, sig_sync_edge: parameterized synchronizer plus rise/fall detector. It is reused by the other PMOD input blocks.

Test Plan (GATE_CYCLES=1000, TIMEOUT_CYCLES=500, CNT_W=16 unless noted):
- 10 MHz square on sig_in (period 100 ns) -> period_cycles=10 after the second edge; every freq_valid shows freq_count=100.
- 1 MHz, 25% duty, with FREQ_PERIOD_METER_DUTY_EN -> period_cycles=100, high_cycles=25, freq_count=10. Without the macro -> high_cycles=0.
- Stop sig_in after lock at 10 cycles -> no_signal rises 500 cycles after the last rise and period_cycles holds 10. Restart the signal -> first rise gives no period_valid; second rise gives period_valid with 10.
- Rising edge timed so rise lands on gate_ctr==999 -> that edge is counted in the ending window's freq_count, not the next one.
- CNT_W=8, GATE_CYCLES=1000, sig_in at 50 MHz -> freq_count=255 and overflow=1. Overflow stays 1 until CPU_RESETN is pulsed.
- Assert CPU_RESETN low mid-window at 10 MHz -> all outputs 0, no_signal=1. After release, first freq_valid arrives exactly 1000 cycles later with count 100 (minus the startup edge latency).

Source files
------------

// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock measurement blocks.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURE,
    LOST
  } per_state_e;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Number of bits needed to hold the values 0..n-1 (at least 1).
  function automatic int unsigned cnt_width(input longint unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 64; i++) begin
      if ((64'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, followed by one delay
// flop used to detect rising and falling edges of the synchronized signal.
module sig_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // Shift the raw input through the synchronizer chain, then delay once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;
  assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/freq_period_meter.sv
// Frequency (edges per gate window) and period (cycles between rising edges)
// meter for an external clock sampled by CLK100MHZ.
// Optional high-time measurement enabled by FREQ_PERIOD_METER_DUTY_EN.
module freq_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES    = CLK_HZ,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2 * CLK_HZ
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic [CNT_W-1:0] period_cycles,
  output logic             period_valid,
  output logic [CNT_W-1:0] high_cycles,
  output logic             no_signal,
  output logic             overflow
);

  localparam int unsigned        GATE_W    = cnt_width(GATE_CYCLES);
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam longint unsigned    TO_LAST   = longint'(TIMEOUT_CYCLES) - 1;

  logic sync, rise, fall;

  sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (CLK100MHZ),
    .rst_ni (CPU_RESETN),
    .async_i(sig_in),
    .sync_o (sync),
    .rise_o (rise),
    .fall_o (fall)
  );

  logic [GATE_W-1:0] gate_ctr_q, gate_ctr_d;
  logic [CNT_W-1:0]  edge_ctr_q, edge_ctr_d, edge_sum;
  logic [CNT_W-1:0]  freq_count_q, freq_count_d;
  logic              freq_valid_q, freq_valid_d;
  logic              edge_sat;

  per_state_e        state_q, state_d;
  logic [CNT_W-1:0]  per_ctr_q, per_ctr_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              pvalid_q, pvalid_d;
  logic              nosig_q, nosig_d;
  logic              per_sat;

  logic              hi_sat;
  logic              overflow_q, overflow_d;

  // Gate window: count edges, latch the total (including a rise on the last
  // gate cycle) when the window ends.
  always_comb begin
    gate_ctr_d   = (gate_ctr_q == GATE_LAST) ? '0 : gate_ctr_q + 1'b1;
    edge_sat     = rise && (edge_ctr_q == CNT_MAX);
    edge_sum     = (rise && !edge_sat) ? edge_ctr_q + 1'b1 : edge_ctr_q;
    freq_count_d = freq_count_q;
    freq_valid_d = 1'b0;
    edge_ctr_d   = edge_sum;
    if (gate_ctr_q == GATE_LAST) begin
      freq_count_d = edge_sum;
      freq_valid_d = 1'b1;
      edge_ctr_d   = '0;
    end
  end

  // Period FSM next-state and report logic.
  always_comb begin
    state_d   = state_q;
    per_ctr_d = per_ctr_q;
    period_d  = period_q;
    pvalid_d  = 1'b0;
    nosig_d   = nosig_q;
    per_sat   = 1'b0;
    case (state_q)
      WAIT_FIRST: begin
        per_ctr_d = '0;
        if (rise) begin
          state_d   = MEASURE;
          per_ctr_d = CNT_ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d  = per_ctr_q;
          pvalid_d  = 1'b1;
          per_ctr_d = CNT_ONE;
          nosig_d   = 1'b0;
        end else if (64'(per_ctr_q) >= TO_LAST) begin
          // Leaving on the increment that would reach the limit puts
          // no_signal high exactly TIMEOUT_CYCLES after the last rise.
          state_d   = LOST;
          nosig_d   = 1'b1;
          per_ctr_d = '0;
        end else if (per_ctr_q == CNT_MAX) begin
          per_sat   = 1'b1;
        end else begin
          per_ctr_d = per_ctr_q + 1'b1;
        end
      end
      LOST: begin
        per_ctr_d = '0;
        if (rise) begin
          state_d   = MEASURE;
          per_ctr_d = CNT_ONE;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  // Sticky saturation flag from any counter.
  always_comb begin
    overflow_d = overflow_q | edge_sat | per_sat | hi_sat;
  end

  // State registers for the gate path, period FSM and overflow flag.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      gate_ctr_q   <= '0;
      edge_ctr_q   <= '0;
      freq_count_q <= '0;
      freq_valid_q <= 1'b0;
      state_q      <= WAIT_FIRST;
      per_ctr_q    <= '0;
      period_q     <= '0;
      pvalid_q     <= 1'b0;
      nosig_q      <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      gate_ctr_q   <= gate_ctr_d;
      edge_ctr_q   <= edge_ctr_d;
      freq_count_q <= freq_count_d;
      freq_valid_q <= freq_valid_d;
      state_q      <= state_d;
      per_ctr_q    <= per_ctr_d;
      period_q     <= period_d;
      pvalid_q     <= pvalid_d;
      nosig_q      <= nosig_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef FREQ_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hi_ctr_q, hi_ctr_d;
  logic [CNT_W-1:0] high_q, high_d;

  // High-time counter restarted on each rise, captured on the falling edge.
  always_comb begin
    hi_ctr_d = hi_ctr_q;
    high_d   = high_q;
    hi_sat   = 1'b0;
    if (rise) begin
      hi_ctr_d = CNT_ONE;
    end else if (sync) begin
      if (hi_ctr_q == CNT_MAX) hi_sat = 1'b1;
      else                     hi_ctr_d = hi_ctr_q + 1'b1;
    end
    if (fall && (state_q == MEASURE)) high_d = hi_ctr_q;
  end

  // High-time registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      hi_ctr_q <= '0;
      high_q   <= '0;
    end else begin
      hi_ctr_q <= hi_ctr_d;
      high_q   <= high_d;
    end
  end

  assign high_cycles = high_q;
`else
  logic duty_unused;
  assign duty_unused = sync ^ fall;
  assign hi_sat      = 1'b0;
  assign high_cycles = '0;
`endif

  assign freq_count    = freq_count_q;
  assign freq_valid    = freq_valid_q;
  assign period_cycles = period_q;
  assign period_valid  = pvalid_q;
  assign no_signal     = nosig_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_freq_period_meter.sv
// Directed self-checking bench for freq_period_meter.
module tb_freq_period_meter;

  localparam int unsigned GATE = 1000;
  localparam int unsigned TO   = 500;
  localparam int unsigned W    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         sig   = 1'b0;
  logic [W-1:0] freq_count, period_cycles, high_cycles;
  logic         freq_valid, period_valid, no_signal, overflow;

  logic         rst8_n = 1'b1;
  logic         sig8   = 1'b0;
  logic [7:0]   fc8, pc8, hc8;
  logic         fv8, pv8, ns8, ov8;

  freq_period_meter #(
    .GATE_CYCLES(GATE), .CNT_W(W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .sig_in(sig),
    .freq_count(freq_count), .freq_valid(freq_valid),
    .period_cycles(period_cycles), .period_valid(period_valid),
    .high_cycles(high_cycles), .no_signal(no_signal), .overflow(overflow)
  );

  freq_period_meter #(
    .GATE_CYCLES(GATE), .CNT_W(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(200)
  ) dut8 (
    .CLK100MHZ(clk), .CPU_RESETN(rst8_n), .sig_in(sig8),
    .freq_count(fc8), .freq_valid(fv8),
    .period_cycles(pc8), .period_valid(pv8),
    .high_cycles(hc8), .no_signal(ns8), .overflow(ov8)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned gen_period = 10, gen_high = 5, phase = 0;
  bit          gen_en = 1'b0, fast_en = 1'b0;

  // One cycle: wait for the falling edge, then drive the generators.
  task automatic step();
    @(negedge clk);
    if (gen_en) begin
      sig   = (phase < gen_high);
      phase = (phase + 1 >= gen_period) ? 0 : phase + 1;
    end
    if (fast_en) sig8 = ~sig8;
  endtask

  task automatic start_gen(input int unsigned per, input int unsigned hi);
    gen_period = per;
    gen_high   = hi;
    phase      = 0;
    gen_en     = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    gen_en = 1'b0;
    sig    = 1'b0;
    repeat (3) step();
  endtask

  // Release reset on the same falling edge where the generator starts.
  task automatic release_with_gen(input int unsigned per, input int unsigned hi);
    start_gen(per, hi);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0; rst8_n = 1'b0;
    step();
    n_checks++;
    if ({freq_count, freq_valid, period_cycles, period_valid, high_cycles, no_signal, overflow}
        !== {16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: fc=%0d fv=%0d pc=%0d pv=%0d hc=%0d ns=%0d ov=%0d, want 0 0 0 0 0 1 0",
               freq_count, freq_valid, period_cycles, period_valid, high_cycles, no_signal, overflow);
    end
    n_checks++;
    if ({ns8, ov8, fc8} !== {1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs8: ns=%0d ov=%0d fc=%0d, want 1 0 0", ns8, ov8, fc8);
    end
  endtask

  task automatic test_10mhz();
    int unsigned first_pv = 0, pv_val = 0, ns_at = 1, fv_n = 0;
    int unsigned fv_step [2];
    int unsigned fv_cnt  [2];
    fv_step = '{0, 0};
    fv_cnt  = '{0, 0};
    apply_reset();
    release_with_gen(10, 5);
    for (int unsigned k = 1; k <= 2000; k++) begin
      step();
      if (period_valid && first_pv == 0) begin
        first_pv = k; pv_val = period_cycles; ns_at = no_signal;
      end
      if (freq_valid) begin
        if (fv_n < 2) begin fv_step[fv_n] = k; fv_cnt[fv_n] = freq_count; end
        fv_n++;
      end
    end
    n_checks++;
    if (first_pv != 13) begin n_fail++; $display("FAIL p10_first_valid_step: got %0d want 13", first_pv); end
    n_checks++;
    if (pv_val != 10) begin n_fail++; $display("FAIL p10_period: got %0d want 10", pv_val); end
    n_checks++;
    if (ns_at != 0) begin n_fail++; $display("FAIL p10_no_signal: got %0d want 0", ns_at); end
    n_checks++;
    if (fv_n != 2) begin n_fail++; $display("FAIL p10_freq_valid_count: got %0d want 2", fv_n); end
    n_checks++;
    if (fv_step[0] != 1000) begin n_fail++; $display("FAIL p10_first_freq_step: got %0d want 1000", fv_step[0]); end
    n_checks++;
    if (fv_cnt[0] != 100) begin n_fail++; $display("FAIL p10_freq_w1: got %0d want 100", fv_cnt[0]); end
    n_checks++;
    if (fv_cnt[1] != 100) begin n_fail++; $display("FAIL p10_freq_w2: got %0d want 100", fv_cnt[1]); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL p10_overflow: got %0d want 0", overflow); end
  endtask

  task automatic test_duty();
    int unsigned pv_seen = 0, per = 0, hi = 0, fc = 0, exp_hi;
`ifdef FREQ_PERIOD_METER_DUTY_EN
    exp_hi = 25;
`else
    exp_hi = 0;
`endif
    apply_reset();
    release_with_gen(100, 25);
    for (int unsigned k = 1; k <= 1000; k++) begin
      step();
      if (period_valid && pv_seen == 0) begin
        pv_seen = k; per = period_cycles; hi = high_cycles;
      end
      if (freq_valid) fc = freq_count;
    end
    n_checks++;
    if (per != 100) begin n_fail++; $display("FAIL duty_period: got %0d want 100 (pv step %0d)", per, pv_seen); end
    n_checks++;
    if (hi != exp_hi) begin n_fail++; $display("FAIL duty_high: got %0d want %0d", hi, exp_hi); end
    n_checks++;
    if (fc != 10) begin n_fail++; $display("FAIL duty_freq: got %0d want 10", fc); end
  endtask

  task automatic test_no_signal();
    int unsigned pv_n = 0, ns_step = 0, first_pv = 0, pv_val = 0;
    apply_reset();
    release_with_gen(10, 5);
    for (int unsigned k = 1; k <= 100 && pv_n < 3; k++) begin
      step();
      if (period_valid) pv_n++;
    end
    n_checks++;
    if (pv_n != 3) begin n_fail++; $display("FAIL loss_lock: got %0d pulses want 3", pv_n); end
    gen_en = 1'b0;
    sig    = 1'b0;
    for (int unsigned j = 1; j <= 600; j++) begin
      step();
      if (no_signal && ns_step == 0) ns_step = j;
    end
    n_checks++;
    if (ns_step != 499) begin n_fail++; $display("FAIL loss_timeout_step: got %0d want 499", ns_step); end
    n_checks++;
    if (period_cycles != 10) begin n_fail++; $display("FAIL loss_period_hold: got %0d want 10", period_cycles); end
    start_gen(10, 5);
    for (int unsigned j = 1; j <= 100; j++) begin
      step();
      if (period_valid && first_pv == 0) begin first_pv = j; pv_val = period_cycles; end
    end
    n_checks++;
    if (first_pv != 14) begin n_fail++; $display("FAIL restart_first_valid_step: got %0d want 14", first_pv); end
    n_checks++;
    if (pv_val != 10) begin n_fail++; $display("FAIL restart_period: got %0d want 10", pv_val); end
    n_checks++;
    if (no_signal !== 1'b0) begin n_fail++; $display("FAIL restart_no_signal: got %0d want 0", no_signal); end
  endtask

  task automatic test_gate_boundary();
    int unsigned wn = 0;
    int unsigned wc [3];
    wc = '{99, 99, 99};
    apply_reset();
    step();
    rst_n = 1'b1;
    for (int unsigned k = 1; k <= 3000; k++) begin
      step();
      if (k == 997 || k == 1998) sig = 1'b1;
      if (k == 1002 || k == 2003) sig = 1'b0;
      if (freq_valid) begin
        if (wn < 3) wc[wn] = freq_count;
        wn++;
      end
    end
    n_checks++;
    if (wc[0] != 1) begin n_fail++; $display("FAIL gate_last_cycle_edge: got %0d want 1", wc[0]); end
    n_checks++;
    if (wc[1] != 0) begin n_fail++; $display("FAIL gate_next_window: got %0d want 0", wc[1]); end
    n_checks++;
    if (wc[2] != 1) begin n_fail++; $display("FAIL gate_first_cycle_edge: got %0d want 1", wc[2]); end
  endtask

  task automatic test_overflow();
    int unsigned fc = 0, pv_n = 0, ov_early = 1, exp_hc;
`ifdef FREQ_PERIOD_METER_DUTY_EN
    exp_hc = 1;
`else
    exp_hc = 0;
`endif
    sig8    = 1'b0;
    fast_en = 1'b1;
    step();
    rst8_n = 1'b1;
    for (int unsigned k = 1; k <= 1000; k++) begin
      step();
      if (k == 100) ov_early = ov8;
      if (k > 100 && k <= 200 && pv8) pv_n++;
      if (fv8) fc = fc8;
    end
    n_checks++;
    if (ov_early != 0) begin n_fail++; $display("FAIL ovf_early: got %0d want 0", ov_early); end
    n_checks++;
    if (pv_n != 50) begin n_fail++; $display("FAIL fast_period_pulses: got %0d want 50", pv_n); end
    n_checks++;
    if (pc8 != 2) begin n_fail++; $display("FAIL fast_period: got %0d want 2", pc8); end
    n_checks++;
    if (hc8 != exp_hc) begin n_fail++; $display("FAIL fast_high: got %0d want %0d", hc8, exp_hc); end
    n_checks++;
    if (fc != 255) begin n_fail++; $display("FAIL ovf_freq_sat: got %0d want 255", fc); end
    n_checks++;
    if (ov8 !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0d want 1", ov8); end
    fast_en = 1'b0;
    sig8    = 1'b0;
    repeat (1200) step();
    n_checks++;
    if (ov8 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0d want 1", ov8); end
    rst8_n = 1'b0;
    #1;
    n_checks++;
    if ({ov8, ns8, fc8} !== {1'b0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL ovf_cleared: ov=%0d ns=%0d fc=%0d want 0 1 0", ov8, ns8, fc8);
    end
    step();
    rst8_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    int unsigned early_fv = 0, fv_at = 0, fc = 0;
    apply_reset();
    release_with_gen(10, 5);
    repeat (500) step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({freq_count, freq_valid, period_cycles, period_valid, high_cycles, no_signal, overflow}
        !== {16'd0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: fc=%0d fv=%0d pc=%0d pv=%0d hc=%0d ns=%0d ov=%0d, want 0 0 0 0 0 1 0",
               freq_count, freq_valid, period_cycles, period_valid, high_cycles, no_signal, overflow);
    end
    gen_en = 1'b0;
    sig    = 1'b0;
    repeat (3) step();
    release_with_gen(10, 5);
    for (int unsigned k = 1; k <= 1000; k++) begin
      step();
      if (freq_valid) begin
        if (k < 1000) early_fv++;
        else begin fv_at = k; fc = freq_count; end
      end
    end
    n_checks++;
    if (early_fv != 0) begin n_fail++; $display("FAIL midreset_early_valid: got %0d want 0", early_fv); end
    n_checks++;
    if (fv_at != 1000) begin n_fail++; $display("FAIL midreset_valid_step: got %0d want 1000", fv_at); end
    n_checks++;
    if (fc != 100) begin n_fail++; $display("FAIL midreset_freq: got %0d want 100", fc); end
  endtask

  initial begin
    test_reset();
    test_10mhz();
    test_duty();
    test_no_signal();
    test_gate_boundary();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
